alu_accum_pipe: RTL and testbench

//  Parametrised two-stage pipelined ALU with accumulator and valid/ready handshake.

---
 rtl/alu_accum_pipe.sv | 169 ++++++++++++++++
 tb/tb_alu_accum_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_accum_pipe.sv
// Two-stage pipelined ALU with accumulator, status flags and valid/ready handshake.
// Optional build macro SAT_ARITH_EN: ADD/SUB saturate to signed max/min on overflow.
module alu_accum_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic             use_acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags,
  output logic [WIDTH-1:0] acc
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_NOT  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NAND = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_XNOR = 4'b0110;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_SHR  = 4'b1010;
  localparam logic [3:0] OP_SHL  = 4'b1011;
  localparam logic [3:0] OP_CLR  = 4'b1111;

  logic             s1_valid_r;
  logic [3:0]       s1_op_r;
  logic             s1_use_acc_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;

  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic [4:0]       flags_r;
  logic [WIDTH-1:0] acc_r;

  logic             s2_adv_s;
  logic             s1_adv_s;
  logic             in_ready_s;

  logic [WIDTH-1:0] opa_s;
  logic [SHW-1:0]   sh_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   dif_s;
  logic [WIDTH:0]   shl_s;
  logic [WIDTH:0]   shr_s;
  logic [WIDTH-1:0] res_s;
  logic             carry_s;
  logic             ovf_s;
  logic             ill_s;
  logic             clr_s;
  logic             zero_s;
  logic             neg_s;

  assign s2_adv_s   = !out_valid_r || out_ready;
  assign s1_adv_s   = s1_valid_r && s2_adv_s;
  assign in_ready_s = !s1_valid_r || s2_adv_s;

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign flags     = flags_r;
  assign acc       = acc_r;

  // ALU datapath on the S1 contents; operand A picks up the live accumulator
  always_comb begin
    opa_s   = s1_use_acc_r ? acc_r : s1_a_r;
    sh_s    = s1_b_r[SHW-1:0];
    sum_s   = {1'b0, opa_s} + {1'b0, s1_b_r};
    dif_s   = {1'b0, opa_s} - {1'b0, s1_b_r};
    // Extra bit on each side catches the last bit shifted out; it stays 0 for amount 0
    shl_s   = {1'b0, opa_s} << sh_s;
    shr_s   = {opa_s, 1'b0} >> sh_s;
    res_s   = {WIDTH{1'b0}};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    ill_s   = 1'b0;
    clr_s   = 1'b0;
    case (s1_op_r)
      OP_AND:  res_s = opa_s & s1_b_r;
      OP_OR:   res_s = opa_s | s1_b_r;
      OP_NOT:  res_s = ~opa_s;
      OP_XOR:  res_s = opa_s ^ s1_b_r;
      OP_NAND: res_s = ~(opa_s & s1_b_r);
      OP_NOR:  res_s = ~(opa_s | s1_b_r);
      OP_XNOR: res_s = ~(opa_s ^ s1_b_r);
      OP_ADD: begin
        res_s   = sum_s[WIDTH-1:0];
        carry_s = sum_s[WIDTH];
        ovf_s   = (opa_s[WIDTH-1] == s1_b_r[WIDTH-1]) && (sum_s[WIDTH-1] != opa_s[WIDTH-1]);
      end
      OP_SUB: begin
        res_s   = dif_s[WIDTH-1:0];
        carry_s = !dif_s[WIDTH];
        ovf_s   = (opa_s[WIDTH-1] != s1_b_r[WIDTH-1]) && (dif_s[WIDTH-1] != opa_s[WIDTH-1]);
      end
      OP_SHR: begin
        res_s   = shr_s[WIDTH:1];
        carry_s = shr_s[0];
      end
      OP_SHL: begin
        res_s   = shl_s[WIDTH-1:0];
        carry_s = shl_s[WIDTH];
      end
      OP_CLR:  clr_s = 1'b1;
      default: ill_s = 1'b1;
    endcase
`ifdef SAT_ARITH_EN
    // Overflow only arises from ADD/SUB; sign of A tells which rail was crossed
    if (ovf_s) begin
      res_s = opa_s[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res_s = res_s;
    end
`endif
    zero_s = (res_s == {WIDTH{1'b0}});
    neg_s  = res_s[WIDTH-1];
  end

  // Stage 1 operand register with its occupancy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r   <= 1'b0;
      s1_op_r      <= 4'b0000;
      s1_use_acc_r <= 1'b0;
      s1_a_r       <= {WIDTH{1'b0}};
      s1_b_r       <= {WIDTH{1'b0}};
    end else if (in_valid && in_ready_s) begin
      s1_valid_r   <= 1'b1;
      s1_op_r      <= opcode;
      s1_use_acc_r <= use_acc;
      s1_a_r       <= a;
      s1_b_r       <= b;
    end else if (s1_adv_s) begin
      s1_valid_r   <= 1'b0;
    end
  end

  // Stage 2 result/flags register and accumulator update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      flags_r     <= 5'b00000;
      acc_r       <= {WIDTH{1'b0}};
    end else if (s2_adv_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        result_r <= res_s;
        flags_r  <= {ill_s, carry_s, ovf_s, neg_s, zero_s};
        if (clr_s) begin
          acc_r <= {WIDTH{1'b0}};
        end else if (!ill_s) begin
          acc_r <= res_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_accum_pipe.sv
// Directed bench for alu_accum_pipe (WIDTH=16): reset, arithmetic, accumulate,
// backpressure, shifts/logic/illegal opcode and mid-operation reset.
module tb_alu_accum_pipe;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opcode;
  logic         use_acc;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [4:0]   flags;
  logic [W-1:0] acc;

  int vectors = 0;
  int miscompares = 0;

  alu_accum_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .use_acc(use_acc), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .acc(acc)
  );

  always #5 clk = ~clk;

  // Presents one beat and returns 1 ns after the edge on which it transferred
  task automatic send(input logic [3:0] op, input logic ua, input logic [W-1:0] av,
                      input logic [W-1:0] bv);
    bit done;
    bit ok;
    done = 1'b0;
    in_valid = 1'b1; opcode = op; use_acc = ua; a = av; b = bv;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) done = 1'b1;
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout op=%b got no in_ready within 20 cycles", op);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = 4'b0000; use_acc = 1'b0; a = 16'h0000; b = 16'h0000;
    #12;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    vectors++; if (result !== 16'h0000) begin miscompares++; $display("FAIL reset_result got=%h exp=0000", result); end
    vectors++; if (flags !== 5'b00000) begin miscompares++; $display("FAIL reset_flags got=%b exp=00000", flags); end
    vectors++; if (acc !== 16'h0000) begin miscompares++; $display("FAIL reset_acc got=%h exp=0000", acc); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        miscompares++; $display("FAIL idle_after_reset cyc=%0d in_ready=%b out_valid=%b exp 1/0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_overflow();
    logic [3:0]   op [2];
    logic [W-1:0] av [2];
    logic [W-1:0] bv [2];
    logic [W-1:0] er [2];
    logic [4:0]   ef [2];
    op[0] = 4'b1000; av[0] = 16'h7FFF; bv[0] = 16'h0001;
    op[1] = 4'b1001; av[1] = 16'h8000; bv[1] = 16'h0001;
`ifdef SAT_ARITH_EN
    er[0] = 16'h7FFF; ef[0] = 5'b00100;
    er[1] = 16'h8000; ef[1] = 5'b01110;
`else
    er[0] = 16'h8000; ef[0] = 5'b00110;
    er[1] = 16'h7FFF; ef[1] = 5'b01100;
`endif
    for (int i = 0; i < 2; i++) begin
      send(op[i], 1'b0, av[i], bv[i]);
      in_valid = 1'b0;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_early_valid i=%0d got=%b exp=0", i, out_valid); end
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b1 || result !== er[i] || flags !== ef[i]) begin
        miscompares++; $display("FAIL ovf_result i=%0d got v=%b r=%h f=%b exp v=1 r=%h f=%b", i, out_valid, result, flags, er[i], ef[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    send(4'b1000, 1'b0, 16'd5, 16'd3);
    send(4'b1000, 1'b1, 16'hDEAD, 16'd2);
    vectors++; if (out_valid !== 1'b1 || result !== 16'd8 || acc !== 16'd8) begin
      miscompares++; $display("FAIL b2b_first got v=%b r=%h acc=%h exp v=1 r=0008 acc=0008", out_valid, result, acc);
    end
    send(4'b1001, 1'b1, 16'hBEEF, 16'd10);
    vectors++; if (out_valid !== 1'b1 || result !== 16'd10 || acc !== 16'd10) begin
      miscompares++; $display("FAIL b2b_second got v=%b r=%h acc=%h exp v=1 r=000a acc=000a", out_valid, result, acc);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b1 || result !== 16'd0 || flags !== 5'b01001 || acc !== 16'd0) begin
      miscompares++; $display("FAIL b2b_third got v=%b r=%h f=%b acc=%h exp v=1 r=0000 f=01001 acc=0000", out_valid, result, flags, acc);
    end
  endtask

  task automatic test_stall();
    logic [3:0]   op [3];
    logic [W-1:0] av [3];
    logic [W-1:0] bv [3];
    logic [W-1:0] er [3];
    int idx;
    int accepted;
    int k;
    bit xfer;
    op[0] = 4'b1000; av[0] = 16'h0001; bv[0] = 16'h0002; er[0] = 16'h0003;
    op[1] = 4'b0011; av[1] = 16'hF0F0; bv[1] = 16'h0FF0; er[1] = 16'hFF00;
    op[2] = 4'b0001; av[2] = 16'h0011; bv[2] = 16'h1100; er[2] = 16'h1111;
    idle(2);
    out_ready = 1'b0;
    idx = 0; accepted = 0; k = 0;
    in_valid = 1'b1; opcode = op[0]; use_acc = 1'b0; a = av[0]; b = bv[0];
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); xfer = in_valid && in_ready;
      @(posedge clk); #1;
      if (xfer) begin
        accepted++; idx++;
        if (idx < 3) begin opcode = op[idx]; a = av[idx]; b = bv[idx]; end
        else in_valid = 1'b0;
      end
      if (c > 0) begin
        vectors++; if (out_valid !== 1'b1 || result !== er[0]) begin
          miscompares++; $display("FAIL stall_hold c=%0d got v=%b r=%h exp v=1 r=%h", c, out_valid, result, er[0]);
        end
      end
    end
    vectors++; if (accepted != 2) begin miscompares++; $display("FAIL stall_accepted got=%0d exp=2", accepted); end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        vectors++;
        if (k >= 3) begin miscompares++; $display("FAIL stall_extra_beat got r=%h exp none", result); end
        else if (result !== er[k]) begin miscompares++; $display("FAIL stall_order k=%0d got=%h exp=%h", k, result, er[k]); end
        k++;
      end
      xfer = in_valid && in_ready;
      @(posedge clk); #1;
      if (xfer) begin
        idx++;
        if (idx < 3) begin opcode = op[idx]; a = av[idx]; b = bv[idx]; end
        else in_valid = 1'b0;
      end
    end
    vectors++; if (k != 3) begin miscompares++; $display("FAIL stall_count got=%0d exp=3", k); end
  endtask

  task automatic test_logic();
    logic [3:0]   op [7];
    logic [W-1:0] av [7];
    logic [W-1:0] bv [7];
    logic [W-1:0] er [7];
    logic [4:0]   ef [7];
    op[0] = 4'b0010; av[0] = 16'h00FF; bv[0] = 16'h1234; er[0] = 16'hFF00; ef[0] = 5'b00010;
    op[1] = 4'b0100; av[1] = 16'hFFFF; bv[1] = 16'hFFFF; er[1] = 16'h0000; ef[1] = 5'b00001;
    op[2] = 4'b0101; av[2] = 16'h0F00; bv[2] = 16'h00F0; er[2] = 16'hF00F; ef[2] = 5'b00010;
    op[3] = 4'b0110; av[3] = 16'h1234; bv[3] = 16'h1234; er[3] = 16'hFFFF; ef[3] = 5'b00010;
    op[4] = 4'b0000; av[4] = 16'h00F0; bv[4] = 16'h0FF0; er[4] = 16'h00F0; ef[4] = 5'b00000;
    op[5] = 4'b1001; av[5] = 16'h0003; bv[5] = 16'h0005; er[5] = 16'hFFFE; ef[5] = 5'b00010;
    op[6] = 4'b1111; av[6] = 16'h5555; bv[6] = 16'hAAAA; er[6] = 16'h0000; ef[6] = 5'b00001;
    for (int i = 0; i < 7; i++) begin
      send(op[i], 1'b0, av[i], bv[i]);
      in_valid = 1'b0;
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b1 || result !== er[i] || flags !== ef[i]) begin
        miscompares++; $display("FAIL logic op=%b got v=%b r=%h f=%b exp v=1 r=%h f=%b", op[i], out_valid, result, flags, er[i], ef[i]);
      end
    end
    vectors++; if (acc !== 16'h0000) begin miscompares++; $display("FAIL clear_acc got=%h exp=0000", acc); end
  endtask

  task automatic test_shift_illegal();
    send(4'b1011, 1'b0, 16'h0001, 16'd15);
    in_valid = 1'b0; @(posedge clk); #1;
    vectors++; if (result !== 16'h8000 || flags !== 5'b00010) begin
      miscompares++; $display("FAIL shl got r=%h f=%b exp r=8000 f=00010", result, flags);
    end
    send(4'b1010, 1'b0, 16'h0003, 16'd1);
    in_valid = 1'b0; @(posedge clk); #1;
    vectors++; if (result !== 16'h0001 || flags !== 5'b01000 || acc !== 16'h0001) begin
      miscompares++; $display("FAIL shr got r=%h f=%b acc=%h exp r=0001 f=01000 acc=0001", result, flags, acc);
    end
    send(4'b0111, 1'b0, 16'h0055, 16'h0066);
    in_valid = 1'b0; @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b1 || result !== 16'h0000 || flags[4] !== 1'b1 || acc !== 16'h0001) begin
      miscompares++; $display("FAIL illegal got v=%b r=%h ill=%b acc=%h exp v=1 r=0000 ill=1 acc=0001", out_valid, result, flags[4], acc);
    end
  endtask

  task automatic test_reset_midop();
    idle(2);
    out_ready = 1'b0;
    send(4'b1000, 1'b0, 16'd7, 16'd0);
    send(4'b1000, 1'b0, 16'd1, 16'd1);
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || acc !== 16'd7 || in_ready !== 1'b0) begin
      miscompares++; $display("FAIL full_before_reset got v=%b acc=%h rdy=%b exp v=1 acc=0007 rdy=0", out_valid, acc, in_ready);
    end
    #1 rst = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0 || acc !== 16'h0000 || result !== 16'h0000) begin
      miscompares++; $display("FAIL async_reset got v=%b acc=%h r=%h exp v=0 acc=0000 r=0000", out_valid, acc, result);
    end
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    send(4'b1000, 1'b0, 16'd4, 16'd5);
    in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b1 || result !== 16'd9 || acc !== 16'd9) begin
      miscompares++; $display("FAIL post_reset_beat got v=%b r=%h acc=%h exp v=1 r=0009 acc=0009", out_valid, result, acc);
    end
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_dup got v=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_back_to_back();
    test_stall();
    test_logic();
    test_shift_illegal();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
